clock_step_generator: RTL and testbench

Runtime-programmable clock/tick generator that drives the processor and peripheral clock enables on the FPGA board. It supersedes the fixed-constant divider with:
- a loadable half-period;
- square, pulse, single-step and hold modes;
- an enable;
- a synchronised step button for stepping the MIPS core one clock at a time.

All outputs are registered in the clk_in domain.

---
 rtl/clock_step_generator.sv | 155 +++++++++++++++
 tb/tb_clock_step_generator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_generator.sv
// ---------------------------------------------------------------------------
// clock_step_generator
//
// Runtime-programmable clock/tick generator for the processor and peripheral
// clock enables. A loadable divisor D sets the half-period (square mode) or
// the period (pulse mode). A synchronised push button steps the core one
// clock at a time in single-step mode. Hold mode freezes the output.
// All outputs are registered in the clk_in domain.
//
// Ports:
//   clk_in      system clock
//   reset       synchronous, active-high reset
//   enable      1 = run; 0 = freeze counter/clk_out/FSM, tick forced 0
//   mode        00 square, 01 pulse, 10 single-step, 11 hold
//   half_period new divisor value, captured on load (0 is stored as 1)
//   load        one-cycle strobe capturing half_period into D
//   step_btn    asynchronous step request (debounced externally)
//   clk_out     generated clock / pulse
//   tick        one-cycle strobe on every clk_out rising transition
//   busy        single-step high phase in progress
//   count       current counter value (never exceeds D-1)
// ---------------------------------------------------------------------------
module clock_step_generator #(
    parameter int                   CNT_WIDTH    = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_HALF = CNT_WIDTH'(50000000),
    parameter int                   SYNC_STAGES  = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] half_period,
    input  logic                 load,
    input  logic                 step_btn,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HIGH = 1'b1
    } step_state_t;

    logic [CNT_WIDTH-1:0]   d_reg;
    logic [CNT_WIDTH-1:0]   d_last;
    mode_t                  mode_q;
    step_state_t            state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_prev;
    logic                   step_edge;
    logic                   terminal;

    // D is never 0, so D-1 cannot wrap; D = 2^W-1 still fits.
    assign d_last   = d_reg - CNT_WIDTH'(1);
    assign terminal = (count == d_last);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            d_reg     <= DEFAULT_HALF;
            mode_q    <= MODE_SQUARE;
            state     <= S_IDLE;
            sync      <= '0;
            btn_prev  <= 1'b0;
            step_edge <= 1'b0;
        end else begin
            // Button synchroniser and rising-edge detect run in every mode.
            // The edge itself is registered, giving SYNC_STAGES+1 edges of
            // latency from first sample to clk_out rising.
            sync      <= {sync[SYNC_STAGES-2:0], step_btn};
            btn_prev  <= sync[SYNC_STAGES-1];
            step_edge <= sync[SYNC_STAGES-1] & ~btn_prev;

            tick <= 1'b0;

            if (mode_t'(mode) != mode_q) begin
                // A mode change restarts from a clean low phase.
                mode_q  <= mode_t'(mode);
                count   <= '0;
                clk_out <= 1'b0;
                busy    <= 1'b0;
                state   <= S_IDLE;
            end else if (load) begin
                // Load beats a coincident terminal count: no toggle/pulse.
                d_reg <= (half_period == '0) ? CNT_WIDTH'(1) : half_period;
                count <= '0;
            end else if (enable) begin
                case (mode_q)
                    MODE_SQUARE: begin
                        if (terminal) begin
                            count   <= '0;
                            clk_out <= ~clk_out;
                            tick    <= ~clk_out;
                        end else begin
                            count <= count + CNT_WIDTH'(1);
                        end
                    end
                    MODE_PULSE: begin
                        // With D=1 every cycle is terminal, so clk_out stays
                        // high and tick fires every cycle.
                        if (terminal) begin
                            count   <= '0;
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                        end else begin
                            count   <= count + CNT_WIDTH'(1);
                            clk_out <= 1'b0;
                        end
                    end
                    MODE_STEP: begin
                        case (state)
                            S_IDLE: begin
                                count <= '0;
                                if (step_edge) begin
                                    clk_out <= 1'b1;
                                    tick    <= 1'b1;
                                    busy    <= 1'b1;
                                    state   <= S_HIGH;
                                end
                            end
                            S_HIGH: begin
                                // Edges arriving here are dropped, not queued.
                                if (terminal) begin
                                    clk_out <= 1'b0;
                                    busy    <= 1'b0;
                                    count   <= '0;
                                    state   <= S_IDLE;
                                end else begin
                                    count <= count + CNT_WIDTH'(1);
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                    default: begin
                        // Hold: count and clk_out stay frozen.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_step_generator.sv
module tb_clock_step_generator;

    localparam int W = 8;

    logic         clk_in;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic [W-1:0] half_period;
    logic         load;
    logic         step_btn;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] count;

    int checks = 0;
    int errors = 0;

    clock_step_generator #(
        .CNT_WIDTH   (W),
        .DEFAULT_HALF(8'd5),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .half_period(half_period),
        .load       (load),
        .step_btn   (step_btn),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .count      (count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic         rst;
        logic         en;
        logic [1:0]   md;
        logic [W-1:0] hp;
        logic         ld;
        logic         e_clk;
        logic         e_tick;
        logic         e_busy;
        logic [W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic [W-1:0] h, input logic l,
                       input logic c, input logic t, input logic b,
                       input logic [W-1:0] n);
        vec_t v;
        v.rst = r; v.en = e; v.md = m; v.hp = h; v.ld = l;
        v.e_clk = c; v.e_tick = t; v.e_busy = b; v.e_cnt = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic c, input logic t,
                           input logic b, input logic [W-1:0] n);
        chk({tag, " clk_out"}, 32'(clk_out), 32'(c));
        chk({tag, " tick"},    32'(tick),    32'(t));
        chk({tag, " busy"},    32'(busy),    32'(b));
        chk({tag, " count"},   32'(count),   32'(n));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; mode = 2'b00; load = 1'b0;
        half_period = '0; step_btn = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; mode = 2'b00; half_period = '0;
        load = 1'b0; step_btn = 1'b0;

        // rst en mode hp ld | clk tick busy count
        add(1,1,2'b00,0,0, 0,0,0,0);
        add(1,1,2'b00,0,0, 0,0,0,0);
        add(0,1,2'b00,3,1, 0,0,0,0);   // load D=3
        add(0,1,2'b00,0,0, 0,0,0,1);
        add(0,1,2'b00,0,0, 0,0,0,2);
        add(0,1,2'b00,0,0, 1,1,0,0);   // edge 3 rise
        add(0,1,2'b00,0,0, 1,0,0,1);
        add(0,1,2'b00,0,0, 1,0,0,2);
        add(0,1,2'b00,0,0, 0,0,0,0);   // edge 6 fall
        add(0,1,2'b00,0,0, 0,0,0,1);
        add(0,1,2'b00,0,0, 0,0,0,2);
        add(0,1,2'b00,0,0, 1,1,0,0);   // edge 9 rise
        add(0,1,2'b00,0,0, 1,0,0,1);
        add(0,1,2'b00,0,0, 1,0,0,2);
        add(0,1,2'b00,6,1, 1,0,0,0);   // load on terminal: no toggle
        add(0,1,2'b00,0,0, 1,0,0,1);
        add(0,1,2'b00,0,0, 1,0,0,2);
        add(0,1,2'b01,0,0, 0,0,0,0);   // mode 00->01 mid-count clears
        add(0,1,2'b01,0,0, 0,0,0,1);
        add(0,1,2'b01,0,0, 0,0,0,2);
        add(0,1,2'b01,0,0, 0,0,0,3);
        add(0,1,2'b01,0,0, 0,0,0,4);
        add(0,1,2'b01,0,0, 0,0,0,5);
        add(0,1,2'b01,0,0, 1,1,0,0);   // pulse, D=6
        add(0,1,2'b01,0,0, 0,0,0,1);
        add(0,1,2'b01,4,1, 0,0,0,0);   // load D=4
        add(0,1,2'b01,0,0, 0,0,0,1);
        add(0,1,2'b01,0,0, 0,0,0,2);
        add(0,1,2'b01,0,0, 0,0,0,3);
        add(0,1,2'b01,0,0, 1,1,0,0);
        add(0,1,2'b01,0,0, 0,0,0,1);
        add(0,1,2'b01,0,0, 0,0,0,2);
        add(0,1,2'b01,0,0, 0,0,0,3);
        add(0,1,2'b01,0,0, 1,1,0,0);
        add(0,1,2'b01,0,0, 0,0,0,1);
        add(0,1,2'b01,0,1, 0,0,0,0);   // load 0 -> D=1
        add(0,1,2'b01,0,0, 1,1,0,0);
        add(0,1,2'b01,0,0, 1,1,0,0);
        add(0,1,2'b01,0,0, 1,1,0,0);
        add(0,1,2'b11,0,0, 0,0,0,0);   // enter hold
        add(0,1,2'b11,0,0, 0,0,0,0);
        add(0,1,2'b11,2,1, 0,0,0,0);   // load in hold sets D=2
        add(0,1,2'b00,0,0, 0,0,0,0);   // back to square
        add(0,1,2'b00,0,0, 0,0,0,1);
        add(0,1,2'b00,0,0, 1,1,0,0);
        add(0,1,2'b00,0,0, 1,0,0,1);
        add(0,1,2'b00,0,0, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; enable = vecs[i].en; mode = vecs[i].md;
            half_period = vecs[i].hp; load = vecs[i].ld;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_tick,
                    vecs[i].e_busy, vecs[i].e_cnt);
        end

        // Enable freeze: square D=4, freeze at count=2 for 10 cycles.
        do_reset();
        load = 1'b1; half_period = 8'd4; step(); load = 1'b0;
        step(); step();
        chk_all("freeze_pre", 0, 0, 0, 2);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all($sformatf("freeze%0d", i), 0, 0, 0, 2);
        end
        enable = 1'b1;
        step();
        chk_all("resume1", 0, 0, 0, 3);
        step();
        chk_all("resume2", 1, 1, 0, 0);

        // Single-step, D=5, button held 20 cycles: one 5-cycle pulse.
        do_reset();
        mode = 2'b10; step();
        load = 1'b1; half_period = 8'd5; step(); load = 1'b0;
        chk_all("step_idle", 0, 0, 0, 0);
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all($sformatf("hold_btn%0d", i), (i >= 3 && i <= 7),
                    (i == 3), (i >= 3 && i <= 7), (i >= 3 && i <= 7) ? W'(i - 3) : W'(0));
        end
        step_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("released%0d", i), 0, 0, 0, 0);
        end
        // New press from IDLE pulses again; a second press during HIGH is dropped.
        for (int i = 0; i < 15; i++) begin
            step_btn = (i == 0 || i == 4);
            step();
            chk_all($sformatf("repress%0d", i), (i >= 3 && i <= 7),
                    (i == 3), (i >= 3 && i <= 7), (i >= 3 && i <= 7) ? W'(i - 3) : W'(0));
        end

        // Reset mid HIGH at count=2, then confirm D=5 and square mode restored.
        for (int i = 0; i < 6; i++) begin
            step_btn = (i == 0);
            step();
        end
        chk_all("mid_high", 1, 0, 1, 2);
        reset = 1'b1;
        step();
        chk_all("reset_mid", 0, 0, 0, 0);
        reset = 1'b0; mode = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_all($sformatf("post_reset%0d", k), 0, 0, 0, W'(k));
        end
        step();
        chk_all("post_reset5", 1, 1, 0, 0);

        // Maximum divisor D = 2^W-1.
        do_reset();
        load = 1'b1; half_period = 8'hFF; step(); load = 1'b0;
        for (int k = 1; k <= 254; k++) begin
            step();
            chk($sformatf("dmax_cnt%0d", k), 32'(count), 32'(k));
            chk($sformatf("dmax_clk%0d", k), 32'(clk_out), 32'(0));
        end
        step();
        chk_all("dmax_term", 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
